// File: rtl/alu_share_arb.sv
// Round-robin arbiter that time-shares one combinational ALU between two
// valid/ready clients, holding the registered result until the owner takes it.

module alu #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [3:0]       i_op,
  output logic [WIDTH-1:0] o_result,
  output logic             o_illegal
);
  localparam int SHW = $clog2(WIDTH);

  logic [SHW-1:0] w_shamt;
  assign w_shamt = i_b[SHW-1:0];

  always_comb begin
    o_result  = '0;
    o_illegal = 1'b0;
    case (i_op)
      4'b0000: o_result = i_a + i_b;
      4'b0001: o_result = i_a - i_b;
      4'b0010: o_result = i_a << w_shamt;
      4'b0011: o_result = {{(WIDTH-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
      4'b0100: o_result = {{(WIDTH-1){1'b0}}, (i_a < i_b)};
      4'b0101: o_result = i_a ^ i_b;
      4'b0110: o_result = i_a >> w_shamt;
      4'b0111: o_result = $signed(i_a) >>> w_shamt;
      4'b1000: o_result = i_a | i_b;
      4'b1001: o_result = i_a & i_b;
      default: o_illegal = 1'b1;
    endcase
  end
endmodule

module alu_share_arb #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [3:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [3:0]       req1_op,
  output logic             resp0_valid,
  input  logic             resp0_ready,
  output logic             resp1_valid,
  input  logic             resp1_ready,
  output logic [WIDTH-1:0] resp_result,
  output logic             resp_zero,
  output logic             resp_err,
  output logic             busy
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]       r_state;
  logic             r_last_grant;
  logic             r_owner;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [3:0]       r_op;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             r_err;

  logic             w_idle;
  logic             w_grant0;
  logic             w_grant1;
  logic [WIDTH-1:0] w_alu_result;
  logic             w_alu_illegal;
  logic [WIDTH-1:0] w_result_final;
  logic             w_owner_ready;

  // A tie goes to whichever client did not win last; a lone requester always wins.
  assign w_idle   = rst_n && (r_state == S_IDLE);
  assign w_grant0 = w_idle && req0_valid && (!req1_valid || r_last_grant);
  assign w_grant1 = w_idle && req1_valid && (!req0_valid || !r_last_grant);

  assign req0_ready = w_grant0;
  assign req1_ready = w_grant1;

  alu #(.WIDTH(WIDTH)) u_alu (
    .i_a       (r_a),
    .i_b       (r_b),
    .i_op      (r_op),
    .o_result  (w_alu_result),
    .o_illegal (w_alu_illegal)
  );

  assign w_result_final = w_alu_illegal ? '0 : w_alu_result;
  assign w_owner_ready  = r_owner ? resp1_ready : resp0_ready;

  // Operand capture needs no reset: it is only consumed after a fresh accept.
  always_ff @(posedge clk) begin
    if (w_grant0) begin
      r_a  <= req0_a;
      r_b  <= req0_b;
      r_op <= req0_op;
    end else if (w_grant1) begin
      r_a  <= req1_a;
      r_b  <= req1_b;
      r_op <= req1_op;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_last_grant <= 1'b1;
      r_owner      <= 1'b0;
      r_result     <= '0;
      r_zero       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_grant0 || w_grant1) begin
            r_owner      <= w_grant1;
            r_last_grant <= w_grant1;
            r_state      <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_result <= w_result_final;
          r_zero   <= (w_result_final == '0);
          r_err    <= w_alu_illegal;
          r_state  <= S_RESP;
        end
        S_RESP: begin
          if (w_owner_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign resp0_valid = (r_state == S_RESP) && !r_owner;
  assign resp1_valid = (r_state == S_RESP) && r_owner;
  assign resp_result = r_result;
  assign resp_zero   = r_zero;
  assign resp_err    = r_err;
  assign busy        = (r_state != S_IDLE);
endmodule

// File: doc/alu_share_arb.md
# alu_share_arb

Two-requester arbiter that time-shares one `alu` datapath instance between independent clients, e.g. the integer pipe and an address-generation or multi-cycle helper unit. Each client has its own valid/ready request channel and valid/ready response channel. The block arbitrates round-robin, registers the winning operands, evaluates them through the shared ALU, and holds the result until the owning client accepts it. It sits between the clients and the single `alu` instance, which it owns exclusively.

## Interface
- WIDTH, 32, operand/result width passed to the shared `alu`
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous, active-low reset, sampled on rising clk
- req0_valid  input  1  client 0 request present
- req0_ready  output  1  client 0 request accepted this cycle when high with req0_valid
- req0_a, req0_b  input  WIDTH  client 0 operands
- req0_op  input  4  client 0 ALU control code
- req1_valid, req1_ready, req1_a, req1_b, req1_op  same as client 0, for client 1
- resp0_valid  output  1  result for client 0 held
- resp0_ready  input  1  client 0 takes result
- resp1_valid, resp1_ready  same, for client 1
- resp_result  output  WIDTH  registered result, shared by both response channels
- resp_zero  output  1  registered result == 0
- resp_err  output  1  request carried an illegal op code
- busy  output  1  high in EXEC or RESP

## Operation
- States: IDLE, EXEC, RESP. Reset state is IDLE.
- Legal op codes: 0000 add, 0001 sub, 0010 sll, 0011 slt, 0100 sltu, 0101 xor, 0110 srl, 0111 sra, 1000 or, 1001 and. Codes 1010–1111 are illegal.
- IDLE, arbitration:
  - reqN_ready is driven combinationally from state, last_grant, and the other client's valid.
  - Only one ready may be high in a cycle.
  - When both clients are valid, grant goes to the client that is not last_grant.
  - When one client is valid, it wins.
  - When neither is valid, both readies are low.
  - A winner is never blocked by a ready deassertion.
- Accept (reqN_valid & reqN_ready):
  - Latch a, b, op, and owner into registers.
  - Set last_grant to N.
  - Go to EXEC.
- EXEC:
  - The shared ALU sees only the latched operands; live request inputs never reach it.
  - Capture resp_result = ALU result (forced to 0 for an illegal op).
  - Capture resp_zero = (resp_result == 0) and resp_err = op illegal.
  - Go to RESP.
- RESP:
  - respN_valid is high for the owner only.
  - On respN_ready the transaction retires and the state goes to IDLE.
  - A new request is not accepted in the same cycle; readies are low outside IDLE.
- Shift amounts use the low 5 bits of b for WIDTH=32, per ALU semantics.
- Arithmetic wraps modulo 2^WIDTH; no overflow flag.
- resp_result, resp_zero, and resp_err are stable throughout RESP and hold their last values in IDLE.

## Timing
- Reset values:
  - state IDLE, last_grant = 1 (so client 0 wins the first tie).
  - resp0_valid = resp1_valid = 0, resp_result = 0, resp_zero = 0, resp_err = 0, busy = 0.
  - req0_ready and req1_ready are 0 while rst_n is low.
- Latency: accept at edge T; EXEC during T→T+1; respN_valid high from T+2.
- Minimum initiation interval is 3 cycles per transaction. Response backpressure extends RESP indefinitely.
- Once a request is accepted, its inputs may change freely.
- A request not accepted must stay valid; the arbiter does not require stable operands before acceptance.
- Reset mid-transaction (rst_n low in EXEC or RESP): the transaction is dropped with no response, and the state returns to IDLE on that edge.
- Simultaneous events:
  - Both clients valid in IDLE: exactly one is accepted, and the other waits at least 3 cycles.
  - A request valid while the block is in RESP is not accepted until after retirement.

## Test plan
- Single request: client 0, add 0x7FFFFFFF + 1 at T → resp0_valid at T+2, resp_result = 0x80000000, zero = 0, err = 0; resp1_valid stays 0.
- Tie fairness: both clients hold valid continuously with sub 5−5 and xor 0xF0F0^0x0F0F, with resp_ready tied high → grants alternate 0,1,0,1. Client 0 gets result 0 with zero = 1; client 1 gets 0xFFFF. The period is 3 cycles.
- Backpressure: client 1, sra 0x80000000 by 4, resp1_ready low for 5 cycles → resp_result = 0xF8000000 held stable. Both readies stay low. Retirement occurs on the cycle resp1_ready rises.
- Illegal op: client 0, op 1100 → resp_result = 0, resp_err = 1. The next legal op returns err = 0.
- Compare ops: slt 0xFFFFFFFF vs 1 → 1; sltu with the same operands → 0; sll 1 by 31 → 0x80000000.
- Reset mid-op: rst_n low during EXEC → no respN_valid ever for that request. After reset, client 0 wins a tie.
